// File: rtl/pingpang_pkg.sv
// Shared types and tile-geometry helpers for the ping-pong tile scheduler.
// The fetch FSM state type lives here so the top level and the bench can name the states.
package pingpang_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_PUSH = 2'd3
    } fetch_state_t;

    // 32-bit memory words needed to fill one buffer bank (one tile)
    function automatic int calc_wpt(input int dwidth, input int aw_r, input int aw_w);
        return ((1 << aw_r) * (1 << aw_w) * dwidth) / 32;
    endfunction

    // Buffer rows handed to the consumer per tile
    function automatic int calc_rows(input int aw_w);
        return 1 << aw_w;
    endfunction

endpackage

// File: rtl/pingpang_sched_if.sv
// Memory read bus, ping-pong buffer handshakes and consumer handshake of the scheduler.
// master = scheduler side, slave = memory/buffer/consumer side.
interface pingpang_sched_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              buf_wr_acq;
    logic [31:0]       buf_wr_data;
    logic              buf_wr_rdy;
    logic              buf_rd_acq;
    logic              buf_rd_rdy;

    logic              pe_ready;
    logic              pe_valid;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output buf_wr_acq, buf_wr_data,
        input  buf_wr_rdy,
        output buf_rd_acq,
        input  buf_rd_rdy,
        input  pe_ready,
        output pe_valid
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  buf_wr_acq, buf_wr_data,
        output buf_wr_rdy,
        input  buf_rd_acq,
        output buf_rd_rdy,
        output pe_ready,
        input  pe_valid
    );
endinterface

// File: rtl/pingpang_fetch.sv
// Fetch engine: reads one word at a time from memory and pushes it into the ping-pong buffer.
// Only one read is ever outstanding; the word is parked in hold_reg until the buffer takes it.
module pingpang_fetch
    import pingpang_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch,
    input  logic [ADDR_W-1:0] launch_addr,
    input  logic [CNT_W-1:0]  launch_total,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              buf_wr_acq,
    output logic [31:0]       buf_wr_data,
    input  logic              buf_wr_rdy,
    output logic              idle
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  fetched_reg, fetched_next;
    logic [CNT_W-1:0]  total_reg, total_next;
    logic [31:0]       hold_reg, hold_next;
    logic [CNT_W-1:0]  fetched_inc;

    assign fetched_inc = fetched_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= F_IDLE;
            addr_reg    <= '0;
            fetched_reg <= '0;
            total_reg   <= '0;
            hold_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            fetched_reg <= fetched_next;
            total_reg   <= total_next;
            hold_reg    <= hold_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        fetched_next = fetched_reg;
        total_next   = total_reg;
        hold_next    = hold_reg;
        mem_req      = 1'b0;
        buf_wr_acq   = 1'b0;

        case (state_reg)
            F_IDLE: begin
                if (launch) begin
                    addr_next    = launch_addr;
                    total_next   = launch_total;
                    fetched_next = '0;
                    state_next   = F_REQ;
                end
            end
            F_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_next = F_WAIT;
                end
            end
            F_WAIT: begin
                // read data arriving in any other state is not ours and is dropped
                if (mem_rvalid) begin
                    hold_next  = mem_rdata;
                    state_next = F_PUSH;
                end
            end
            F_PUSH: begin
                buf_wr_acq = 1'b1;
                if (buf_wr_rdy) begin
                    addr_next    = addr_reg + 1'b1;
                    fetched_next = fetched_inc;
                    state_next   = (fetched_inc == total_reg) ? F_IDLE : F_REQ;
                end
            end
            default: begin
                state_next = F_IDLE;
            end
        endcase
    end

    assign mem_addr    = addr_reg;
    assign buf_wr_data = hold_reg;
    assign idle        = (state_reg == F_IDLE);

endmodule

// File: rtl/pingpang_sched.sv
// Ping-pong tile scheduler: fetches num_tiles tiles from memory into a double buffer and
// drains buffer rows to a consumer, pulsing done once every row has been handed over.
module pingpang_sched
    import pingpang_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH_r = 2,
    parameter int AWIDTH_w = 2,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_tiles,
    output logic              busy,
    output logic              done,
    pingpang_sched_if.master  bus
);

    localparam int WPT    = calc_wpt(DWIDTH, AWIDTH_r, AWIDTH_w);
    localparam int ROWS   = calc_rows(AWIDTH_w);
    localparam int WCNT_W = 8 + $clog2(WPT);
    localparam int RCNT_W = 8 + $clog2(ROWS);

    logic              busy_reg;
    logic              done_reg;
    logic [7:0]        tiles_reg;
    logic [RCNT_W-1:0] read_cnt_reg;
    logic              pe_valid_reg;

    logic              accept;
    logic              launch;
    logic              zero_job;
    logic              finish;
    logic              rd_acq;
    logic              fetch_idle;
    logic [WCNT_W-1:0] total_words;
    logic [RCNT_W-1:0] total_rows;

    // start is only looked at while no job is running
    assign accept      = start & ~busy_reg;
    assign zero_job    = accept & (num_tiles == 8'd0);
    assign launch      = accept & (num_tiles != 8'd0);
    assign total_words = WCNT_W'(num_tiles) * WCNT_W'(WPT);
    assign total_rows  = RCNT_W'(tiles_reg) * RCNT_W'(ROWS);

    pingpang_fetch #(
        .ADDR_W (ADDR_W),
        .CNT_W  (WCNT_W)
    ) u_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .launch       (launch),
        .launch_addr  (base_addr),
        .launch_total (total_words),
        .mem_req      (bus.mem_req),
        .mem_addr     (bus.mem_addr),
        .mem_gnt      (bus.mem_gnt),
        .mem_rvalid   (bus.mem_rvalid),
        .mem_rdata    (bus.mem_rdata),
        .buf_wr_acq   (bus.buf_wr_acq),
        .buf_wr_data  (bus.buf_wr_data),
        .buf_wr_rdy   (bus.buf_wr_rdy),
        .idle         (fetch_idle)
    );

    // Drain side runs on its own: a row is taken whenever the buffer has one and the consumer is free
    assign rd_acq = busy_reg & (read_cnt_reg < total_rows) & bus.buf_rd_rdy & bus.pe_ready;

    // The cycle read_cnt completes is also the cycle the final pe_valid is on the wire,
    // so done/busy change on the following edge, after the last row has been issued.
    assign finish = busy_reg & fetch_idle & (read_cnt_reg == total_rows);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            tiles_reg    <= '0;
            read_cnt_reg <= '0;
            pe_valid_reg <= 1'b0;
        end else begin
            done_reg     <= zero_job | finish;
            pe_valid_reg <= rd_acq;
            if (launch) begin
                busy_reg     <= 1'b1;
                tiles_reg    <= num_tiles;
                read_cnt_reg <= '0;
            end else begin
                if (finish) begin
                    busy_reg <= 1'b0;
                end
                read_cnt_reg <= read_cnt_reg + RCNT_W'(rd_acq);
            end
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign bus.buf_rd_acq = rd_acq;
    assign bus.pe_valid   = pe_valid_reg;

endmodule

// File: tb/tb_pingpang_sched.sv
// Bench for pingpang_sched: a behavioural memory and ping-pong buffer drive the DUT; each test
// task compares the logged bus traffic against the address/data sequence a job must produce.
module tb_pingpang_sched;
    localparam int DWIDTH   = 8;
    localparam int AWIDTH_r = 2;
    localparam int AWIDTH_w = 2;
    localparam int ADDR_W   = 16;
    // the buffer model stores one 32-bit word per row, which holds for the default geometry
    localparam int WPT  = ((1 << AWIDTH_r) * (1 << AWIDTH_w) * DWIDTH) / 32;
    localparam int ROWS = 1 << AWIDTH_w;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        num_tiles;
    logic              busy;
    logic              done;

    pingpang_sched_if #(.ADDR_W(ADDR_W)) bus ();

    pingpang_sched #(
        .DWIDTH   (DWIDTH),
        .AWIDTH_r (AWIDTH_r),
        .AWIDTH_w (AWIDTH_w),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_tiles (num_tiles),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // environment knobs, written by the test tasks
    bit gnt_rand, pe_toggle, spur_en, wr_block;
    int lat_min, lat_max;

    // memory and buffer model state plus traffic logs, owned by the model process
    bit          pend;
    int          lat_cnt;
    logic [15:0] pend_addr;
    logic [31:0] bank [2][WPT];
    int          wcnt [2];
    int          rcnt [2];
    bit          full [2];
    int          wb, rb;
    logic [31:0] rd_data_m;
    bit          pe_tog;
    int          cyc, done_cnt, rd_cnt, first_rd_cyc, last_wr_cyc, overlap_err, acq_err;
    logic [15:0] addr_q [$];
    logic [31:0] wr_q [$];
    logic [31:0] pe_q [$];

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, a};
    endfunction

    // mismatches between logged traffic and the job's reference word stream
    function automatic int seq_errors(input logic [15:0] b, input int tiles);
        int n;
        logic [15:0] a;
        n = 0;
        for (int k = 0; k < tiles * WPT; k++) begin
            a = b + 16'(k);
            if (k >= addr_q.size() || addr_q[k] !== a) n++;
            if (k >= wr_q.size() || wr_q[k] !== mem_word(a)) n++;
            if (k >= pe_q.size() || pe_q[k] !== mem_word(a)) n++;
        end
        return n;
    endfunction

    initial begin
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        bus.buf_wr_rdy = 0; bus.buf_rd_rdy = 0; bus.pe_ready = 0;
        pend = 0; lat_cnt = 0; pend_addr = 0; wb = 0; rb = 0; rd_data_m = 0; pe_tog = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin wcnt[i] = 0; rcnt[i] = 0; full[i] = 0; end
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 0; wb = 0; rb = 0; rd_data_m = 0;
                for (int i = 0; i < 2; i++) begin wcnt[i] = 0; rcnt[i] = 0; full[i] = 0; end
                bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
                bus.buf_wr_rdy = 0; bus.buf_rd_rdy = 0; bus.pe_ready = 0;
                continue;
            end
            // outputs produced by the edge just gone
            if (bus.pe_valid) pe_q.push_back(rd_data_m);
            if (done) done_cnt++;
            // inputs for the coming edge
            pe_tog = ~pe_tog;
            bus.pe_ready   = pe_toggle ? pe_tog : 1'b1;
            bus.buf_wr_rdy = !full[wb] && !wr_block;
            bus.buf_rd_rdy = full[rb];
            bus.mem_rvalid = 0;
            bus.mem_rdata  = 0;
            if (pend && lat_cnt == 0) begin
                bus.mem_rvalid = 1;
                bus.mem_rdata  = mem_word(pend_addr);
            end else if (!pend && spur_en && $urandom_range(0, 3) == 0) begin
                bus.mem_rvalid = 1;
                bus.mem_rdata  = $urandom;
            end
            bus.mem_gnt = bus.mem_req && (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
            #1;
            // handshakes that the coming edge will take
            if (bus.mem_req && pend) overlap_err++;
            if (pend && lat_cnt == 0) pend = 0;
            else if (pend) lat_cnt--;
            if (bus.mem_req && bus.mem_gnt) begin
                addr_q.push_back(bus.mem_addr);
                pend = 1;
                pend_addr = bus.mem_addr;
                lat_cnt = $urandom_range(lat_min, lat_max);
            end
            if (bus.buf_wr_acq && bus.buf_wr_rdy) begin
                wr_q.push_back(bus.buf_wr_data);
                bank[wb][wcnt[wb]] = bus.buf_wr_data;
                last_wr_cyc = cyc;
                wcnt[wb]++;
                if (wcnt[wb] == WPT) begin full[wb] = 1; wcnt[wb] = 0; wb ^= 1; end
            end
            if (bus.buf_rd_acq) begin
                if (!(bus.buf_rd_rdy && bus.pe_ready)) acq_err++;
                rd_cnt++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                rd_data_m = bank[rb][rcnt[rb]];
                rcnt[rb]++;
                if (rcnt[rb] == ROWS) begin full[rb] = 0; rcnt[rb] = 0; rb ^= 1; end
            end
        end
    end

    task automatic clear_logs();
        addr_q.delete(); wr_q.delete(); pe_q.delete();
        done_cnt = 0; rd_cnt = 0; first_rd_cyc = -1; last_wr_cyc = -1;
        overlap_err = 0; acq_err = 0;
    endtask

    task automatic set_knobs(input bit g, input int lmin, input int lmax, input bit pt, input bit sp);
        gnt_rand = g; lat_min = lmin; lat_max = lmax; pe_toggle = pt; spur_en = sp; wr_block = 0;
    endtask

    task automatic do_start(input logic [15:0] b, input logic [7:0] t);
        @(posedge clk); #2;
        start = 1; base_addr = b; num_tiles = t;
        @(posedge clk); #2;
        start = 0;
        $display("job start base=0x%04h tiles=%0d", b, t);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #2;
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget); end
        repeat (3) @(posedge clk);
        #2;
        $display("job end %s: reqs=%0d writes=%0d reads=%0d pe_valid=%0d done_pulses=%0d",
                 name, addr_q.size(), wr_q.size(), rd_cnt, pe_q.size(), done_cnt);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({busy, done, bus.mem_req, bus.buf_wr_acq, bus.buf_rd_acq, bus.pe_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy, done, bus.mem_req, bus.buf_wr_acq, bus.buf_rd_acq, bus.pe_valid});
        end
        checks++;
        if (bus.mem_addr !== 16'h0 || bus.buf_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: mem_addr=%h buf_wr_data=%h expected 0", bus.mem_addr, bus.buf_wr_data);
        end
        rst_n = 1;
    endtask

    task automatic test_basic();
        set_knobs(0, 0, 0, 0, 0);
        clear_logs();
        do_start(16'h0100, 8'd1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done("basic", 200);
        checks++;
        if (addr_q.size() != 4 || addr_q[0] !== 16'h0100 || addr_q[3] !== 16'h0103) begin
            errors++; $display("FAIL basic_addr: count=%0d expected 4 starting 0x0100", addr_q.size());
        end
        checks++;
        if (seq_errors(16'h0100, 1) != 0) begin
            errors++; $display("FAIL basic_seq: %0d mismatches expected 0", seq_errors(16'h0100, 1));
        end
        checks++;
        if (wr_q.size() != 4 || rd_cnt != 4) begin
            errors++; $display("FAIL basic_counts: writes=%0d reads=%0d expected 4/4", wr_q.size(), rd_cnt);
        end
        checks++;
        if (first_rd_cyc <= last_wr_cyc) begin
            errors++; $display("FAIL basic_order: first read cyc %0d last write cyc %0d, reads must follow", first_rd_cyc, last_wr_cyc);
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done: pulses=%0d busy=%b expected 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_pe_toggle();
        logic [15:0] b;
        b = 16'($urandom);
        set_knobs(1, 0, 2, 1, 1);
        clear_logs();
        do_start(b, 8'd3);
        wait_done("pe_toggle", 1000);
        checks++;
        if (wr_q.size() != 12 || rd_cnt != 12 || pe_q.size() != 12) begin
            errors++; $display("FAIL toggle_counts: writes=%0d reads=%0d pe_valid=%0d expected 12/12/12", wr_q.size(), rd_cnt, pe_q.size());
        end
        checks++;
        if (seq_errors(b, 3) != 0) begin
            errors++; $display("FAIL toggle_seq: %0d mismatches expected 0", seq_errors(b, 3));
        end
        checks++;
        if (overlap_err != 0 || acq_err != 0 || done_cnt != 1) begin
            errors++; $display("FAIL toggle_proto: overlap=%0d bad_acq=%0d done=%0d expected 0/0/1", overlap_err, acq_err, done_cnt);
        end
    endtask

    task automatic test_wr_stall();
        bit found;
        logic [31:0] held;
        set_knobs(0, 1, 1, 0, 0);
        clear_logs();
        found = 0;
        do_start(16'h0400, 8'd2);
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk); #2;
            if (bus.buf_wr_acq) found = 1;
        end
        wr_block = 1;
        held = bus.buf_wr_data;
        checks++;
        if (!found) begin errors++; $display("FAIL stall_enter: buf_wr_acq=0 expected 1 within 50 cycles"); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            checks++;
            if (bus.buf_wr_acq !== 1'b1 || bus.buf_wr_data !== held || bus.mem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d acq=%b data=%h req=%b expected 1/%h/0", i, bus.buf_wr_acq, bus.buf_wr_data, bus.mem_req, held);
            end
        end
        wr_block = 0;
        wait_done("wr_stall", 500);
        checks++;
        if (addr_q.size() != 8 || seq_errors(16'h0400, 2) != 0) begin
            errors++; $display("FAIL stall_seq: reqs=%0d mismatches=%0d expected 8/0", addr_q.size(), seq_errors(16'h0400, 2));
        end
    endtask

    task automatic test_wrap();
        set_knobs(0, 0, 1, 0, 0);
        clear_logs();
        do_start(16'hFFFE, 8'd1);
        wait_done("wrap", 200);
        checks++;
        if (addr_q.size() != 4 || addr_q[0] !== 16'hFFFE || addr_q[1] !== 16'hFFFF ||
            addr_q[2] !== 16'h0000 || addr_q[3] !== 16'h0001) begin
            errors++; $display("FAIL wrap_addr: count=%0d first=%h last=%h expected FFFE..0001", addr_q.size(), addr_q[0], addr_q[addr_q.size()-1]);
        end
        checks++;
        if (seq_errors(16'hFFFE, 1) != 0 || done_cnt != 1) begin
            errors++; $display("FAIL wrap_seq: mismatches=%0d done=%0d expected 0/1", seq_errors(16'hFFFE, 1), done_cnt);
        end
    endtask

    task automatic test_zero_and_ignore();
        set_knobs(0, 0, 1, 0, 0);
        clear_logs();
        do_start(16'h1234, 8'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done: done=%b busy=%b expected 1/0", done, busy);
        end
        @(posedge clk); #2;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_pulse: done=%b expected 0", done); end
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (addr_q.size() != 0 || done_cnt != 1) begin
            errors++; $display("FAIL zero_bus: reqs=%0d done=%0d expected 0/1", addr_q.size(), done_cnt);
        end
        clear_logs();
        do_start(16'h0800, 8'd2);
        repeat (3) @(posedge clk);
        #2;
        start = 1; base_addr = 16'h0F00; num_tiles = 8'd5;
        @(posedge clk); #2;
        start = 0;
        wait_done("ignore", 500);
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (addr_q.size() != 8 || seq_errors(16'h0800, 2) != 0) begin
            errors++; $display("FAIL ignore_seq: reqs=%0d mismatches=%0d expected 8/0", addr_q.size(), seq_errors(16'h0800, 2));
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL ignore_done: done=%0d busy=%b expected 1/0", done_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        set_knobs(0, 4, 4, 0, 0);
        clear_logs();
        found = 0;
        do_start(16'h0300, 8'd3);
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #2;
            if (addr_q.size() == WPT + 1 && pend) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_reach: tile 2 wait not reached, reqs=%0d", addr_q.size()); end
        #1 rst_n = 0;
        #1;
        checks++;
        if ({busy, done, bus.mem_req, bus.buf_wr_acq, bus.buf_rd_acq, bus.pe_valid} !== 6'b0 ||
            bus.mem_addr !== 16'h0 || bus.buf_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: ctrl=%b addr=%h data=%h expected all 0",
                     {busy, done, bus.mem_req, bus.buf_wr_acq, bus.buf_rd_acq, bus.pe_valid}, bus.mem_addr, bus.buf_wr_data);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_nodone: done=%0d busy=%b expected 0/0", done_cnt, busy);
        end
        set_knobs(0, 0, 1, 0, 0);
        clear_logs();
        do_start(16'h0200, 8'd1);
        wait_done("after_reset", 200);
        checks++;
        if (addr_q.size() != 4 || seq_errors(16'h0200, 1) != 0 || done_cnt != 1) begin
            errors++; $display("FAIL rstmid_rerun: reqs=%0d mismatches=%0d done=%0d expected 4/0/1", addr_q.size(), seq_errors(16'h0200, 1), done_cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] b;
        int t;
        for (int j = 0; j < 4; j++) begin
            b = 16'($urandom);
            t = $urandom_range(1, 6);
            set_knobs(1, 0, 3, 1'($urandom_range(0, 1)), 1);
            clear_logs();
            do_start(b, 8'(t));
            wait_done("random", 2000);
            checks++;
            if (wr_q.size() != t * WPT || rd_cnt != t * ROWS || pe_q.size() != t * ROWS) begin
                errors++; $display("FAIL random_counts: job %0d writes=%0d reads=%0d pe=%0d expected %0d/%0d/%0d",
                                   j, wr_q.size(), rd_cnt, pe_q.size(), t * WPT, t * ROWS, t * ROWS);
            end
            checks++;
            if (seq_errors(b, t) != 0 || overlap_err != 0 || acq_err != 0 || done_cnt != 1) begin
                errors++; $display("FAIL random_seq: job %0d mismatches=%0d overlap=%0d bad_acq=%0d done=%0d expected 0/0/0/1",
                                   j, seq_errors(b, t), overlap_err, acq_err, done_cnt);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 0; start = 0; base_addr = 0; num_tiles = 0;
        set_knobs(0, 0, 0, 0, 0);
        clear_logs();
        test_reset();
        test_basic();
        test_pe_toggle();
        test_wr_stall();
        test_wrap();
        test_zero_and_ignore();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end within 500000 time units");
        $fatal(1);
    end

endmodule
